// File: rtl/md_rx_arbiter.sv
// -----------------------------------------------------------------------------
// md_rx_arbiter
//   Round-robin arbiter that shares the single MD RX channel of the aligner
//   among NUM_REQ sources. The winning beat is captured in one output register
//   stage. The error response from the aligner is returned to the requester
//   that owned the beat.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   s_valid/s_ready       per-requester handshake (s_ready is combinational)
//   s_data/offset/size    packed per-requester payload, requester i = slice i
//   s_err                 per-requester 1-cycle error pulse (registered)
//   md_rx_valid/ready     output handshake towards the aligner
//   md_rx_data/offset/size  buffered beat
//   md_rx_err             aligner error, valid on md_rx_valid && md_rx_ready
//   grant_id              owner of the beat held in the output register
//   busy                  output register holds a beat
// -----------------------------------------------------------------------------
module md_rx_arbiter #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int NUM_REQ         = 4,
  localparam int BUS_BYTES      = ALGN_DATA_WIDTH / 8,
  localparam int OFFSET_W       = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1,
  localparam int SIZE_W         = $clog2(BUS_BYTES) + 1,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              s_valid,
  input  logic [NUM_REQ*ALGN_DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ*OFFSET_W-1:0]     s_offset,
  input  logic [NUM_REQ*SIZE_W-1:0]       s_size,
  output logic [NUM_REQ-1:0]              s_ready,
  output logic [NUM_REQ-1:0]              s_err,
  output logic                            md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]      md_rx_data,
  output logic [OFFSET_W-1:0]             md_rx_offset,
  output logic [SIZE_W-1:0]               md_rx_size,
  input  logic                            md_rx_ready,
  input  logic                            md_rx_err,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // NUM_REQ at the width of the pointer-plus-offset sum used for wrap-around
  localparam logic [ID_W:0] NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t                       state_reg, state_next;
  logic [ID_W-1:0]              rr_ptr_reg;
  logic [ID_W-1:0]              grant_id_reg;
  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data_reg;
  logic [OFFSET_W-1:0]          md_rx_offset_reg;
  logic [SIZE_W-1:0]            md_rx_size_reg;
  logic [NUM_REQ-1:0]           s_err_reg;

  logic [ALGN_DATA_WIDTH-1:0]   data_arr   [NUM_REQ];
  logic [OFFSET_W-1:0]          offset_arr [NUM_REQ];
  logic [SIZE_W-1:0]            size_arr   [NUM_REQ];

  logic                         win_found;
  logic [ID_W-1:0]              win_id;
  logic                         can_load;
  logic                         accept;
  logic [ID_W-1:0]              rr_ptr_next;

  // Unpack the per-requester payload slices
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi]   = s_data[gi*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
      assign offset_arr[gi] = s_offset[gi*OFFSET_W +: OFFSET_W];
      assign size_arr[gi]   = s_size[gi*SIZE_W +: SIZE_W];
    end
  endgenerate

  // Round-robin search starting at rr_ptr; the first valid requester wins
  always_comb begin
    logic [ID_W:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W + 1)'(j);
      if (cand >= NUM_REQ_X) begin
        cand = cand - NUM_REQ_X;
      end
      if (!win_found && s_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // The register can take a new beat when empty or when the aligner is
  // draining the current one this cycle, giving back-to-back throughput.
  assign can_load    = (state_reg == IDLE) || (md_rx_ready && (state_reg == BUSY));
  assign accept      = can_load && win_found && !reset;
  assign rr_ptr_next = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign s_ready[gi] = accept && (win_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) state_next = BUSY;
      BUSY: if (md_rx_ready && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= '0;
      grant_id_reg     <= '0;
      md_rx_data_reg   <= '0;
      md_rx_offset_reg <= '0;
      md_rx_size_reg   <= '0;
      s_err_reg        <= '0;
    end else begin
      state_reg <= state_next;
      // Error pulse for the beat leaving now; independent of any new load
      s_err_reg <= '0;
      if ((state_reg == BUSY) && md_rx_ready) begin
        s_err_reg[grant_id_reg] <= md_rx_err;
      end
      if (accept) begin
        md_rx_data_reg   <= data_arr[win_id];
        md_rx_offset_reg <= offset_arr[win_id];
        md_rx_size_reg   <= size_arr[win_id];
        grant_id_reg     <= win_id;
        rr_ptr_reg       <= rr_ptr_next;
      end
    end
  end

  assign md_rx_valid  = (state_reg == BUSY);
  assign busy         = (state_reg == BUSY);
  assign md_rx_data   = md_rx_data_reg;
  assign md_rx_offset = md_rx_offset_reg;
  assign md_rx_size   = md_rx_size_reg;
  assign grant_id     = grant_id_reg;
  assign s_err        = s_err_reg;

endmodule

// File: tb/tb_md_rx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_md_rx_arbiter
//   Directed testbench for md_rx_arbiter (4 requesters, 32-bit data).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_md_rx_arbiter;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int IW = 2;

  logic                clk;
  logic                reset;
  logic [NR-1:0]       s_valid;
  logic [NR*W-1:0]     s_data;
  logic [NR*OW-1:0]    s_offset;
  logic [NR*SW-1:0]    s_size;
  logic [NR-1:0]       s_ready;
  logic [NR-1:0]       s_err;
  logic                md_rx_valid;
  logic [W-1:0]        md_rx_data;
  logic [OW-1:0]       md_rx_offset;
  logic [SW-1:0]       md_rx_size;
  logic                md_rx_ready;
  logic                md_rx_err;
  logic [IW-1:0]       grant_id;
  logic                busy;

  int checks = 0;
  int errors = 0;

  md_rx_arbiter #(.ALGN_DATA_WIDTH(W), .NUM_REQ(NR)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_offset     (s_offset),
    .s_size       (s_size),
    .s_ready      (s_ready),
    .s_err        (s_err),
    .md_rx_valid  (md_rx_valid),
    .md_rx_data   (md_rx_data),
    .md_rx_offset (md_rx_offset),
    .md_rx_size   (md_rx_size),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input int i, input logic v, input logic [W-1:0] d,
                           input logic [OW-1:0] o, input logic [SW-1:0] sz);
    s_valid[i]         = v;
    s_data[i*W +: W]   = d;
    s_offset[i*OW +: OW] = o;
    s_size[i*SW +: SW] = sz;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    s_valid     = '0;
    s_data      = '0;
    s_offset    = '0;
    s_size      = '0;
    md_rx_ready = 1'b0;
    md_rx_err   = 1'b0;

    tick();
    tick();
    // s_ready must stay low while reset is asserted
    s_valid = 4'b1111;
    #1 check("rst_s_ready", s_ready, 4'b0000);
    tick();
    check("rst_valid", md_rx_valid, 0);
    check("rst_data", md_rx_data, 0);
    check("rst_off", md_rx_offset, 0);
    check("rst_size", md_rx_size, 0);
    check("rst_serr", s_err, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_rrptr", dut.rr_ptr_reg, 0);
    s_valid = '0;
    reset   = 1'b0;

    // 1. single req0 beat
    md_rx_ready = 1'b1;
    drive_req(0, 1'b1, 32'hDEADBEEF, 2'd0, 3'd4);
    #1 check("t1_s_ready", s_ready, 4'b0001);
    tick();
    check("t1_valid", md_rx_valid, 1);
    check("t1_data", md_rx_data, 32'hDEADBEEF);
    check("t1_off", md_rx_offset, 0);
    check("t1_size", md_rx_size, 4);
    check("t1_grant", grant_id, 0);
    check("t1_busy", busy, 1);
    s_valid = '0;
    tick();
    check("t1_idle_valid", md_rx_valid, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_rrptr", dut.rr_ptr_reg, 1);

    // 2. all requesters valid, ready high: 0,1,2,3,0,... with no bubble
    do_reset();
    for (int i = 0; i < NR; i++) drive_req(i, 1'b1, 32'h100 + i, 2'(i), 3'(i + 1));
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("t2_s_ready_%0d", k), s_ready, 4'b0001 << (k % 4));
      tick();
      check($sformatf("t2_valid_%0d", k), md_rx_valid, 1);
      check($sformatf("t2_grant_%0d", k), grant_id, k % 4);
      check($sformatf("t2_data_%0d", k), md_rx_data, 32'h100 + (k % 4));
      check($sformatf("t2_size_%0d", k), md_rx_size, (k % 4) + 1);
    end
    s_valid = '0;
    tick();
    check("t2_idle", md_rx_valid, 0);
    check("t2_rrptr", dut.rr_ptr_reg, 0);

    // 3. hold a req2 beat with ready low for 5 cycles
    md_rx_ready = 1'b0;
    drive_req(2, 1'b1, 32'hCAFE0002, 2'd2, 3'd1);
    #1 check("t3_s_ready", s_ready, 4'b0100);
    tick();
    s_valid = '0;
    drive_req(0, 1'b1, 32'h0A0A0A0A, 2'd1, 3'd2);
    md_rx_err = 1'b1;  // ignored without a handshake
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("t3_hold_ready_%0d", c), s_ready, 4'b0000);
      check($sformatf("t3_hold_valid_%0d", c), md_rx_valid, 1);
      check($sformatf("t3_hold_data_%0d", c), md_rx_data, 32'hCAFE0002);
      check($sformatf("t3_hold_off_%0d", c), md_rx_offset, 2);
      check($sformatf("t3_hold_size_%0d", c), md_rx_size, 1);
      check($sformatf("t3_hold_grant_%0d", c), grant_id, 2);
      check($sformatf("t3_hold_serr_%0d", c), s_err, 0);
      tick();
    end
    md_rx_err   = 1'b0;
    md_rx_ready = 1'b1;
    #1 check("t3_rel_s_ready", s_ready, 4'b0001);  // rr_ptr=3 -> search 3,0
    tick();
    check("t3_next_grant", grant_id, 0);
    check("t3_next_data", md_rx_data, 32'h0A0A0A0A);
    check("t3_next_serr", s_err, 0);
    s_valid = '0;
    tick();
    check("t3_idle", md_rx_valid, 0);

    // 4. error returned on a req1 handshake
    drive_req(1, 1'b1, 32'h11111111, 2'd3, 3'd2);
    #1 check("t4_s_ready", s_ready, 4'b0010);
    tick();
    check("t4_off", md_rx_offset, 3);
    check("t4_size", md_rx_size, 2);
    check("t4_grant", grant_id, 1);
    check("t4_serr_pre", s_err, 0);
    s_valid   = '0;
    md_rx_err = 1'b1;
    tick();
    check("t4_serr_pulse", s_err, 4'b0010);
    check("t4_valid", md_rx_valid, 0);
    md_rx_err = 1'b0;
    tick();
    check("t4_serr_clear", s_err, 0);

    // 5. reset with a beat buffered and ready low
    md_rx_ready = 1'b0;
    drive_req(2, 1'b1, 32'h22222222, 2'd0, 3'd4);
    tick();
    check("t5_loaded", md_rx_valid, 1);
    check("t5_rrptr_pre", dut.rr_ptr_reg, 3);
    s_valid   = '0;
    md_rx_err = 1'b1;
    reset     = 1'b1;
    tick();
    check("t5_valid", md_rx_valid, 0);
    check("t5_rrptr", dut.rr_ptr_reg, 0);
    check("t5_serr", s_err, 0);
    check("t5_busy", busy, 0);
    reset       = 1'b0;
    md_rx_ready = 1'b1;
    tick();
    check("t5_serr_after", s_err, 0);
    check("t5_valid_after", md_rx_valid, 0);
    md_rx_err = 1'b0;

    // 6. req3 alone with rr_ptr=1, then req1
    drive_req(0, 1'b1, 32'h00000000, 2'd0, 3'd1);
    tick();
    s_valid = '0;
    tick();
    check("t6_rrptr1", dut.rr_ptr_reg, 1);
    drive_req(3, 1'b1, 32'h33333333, 2'd1, 3'd1);
    #1 check("t6_s_ready3", s_ready, 4'b1000);
    tick();
    check("t6_grant3", grant_id, 3);
    check("t6_rrptr0", dut.rr_ptr_reg, 0);
    s_valid = '0;
    drive_req(1, 1'b1, 32'h44444444, 2'd2, 3'd2);
    #1 check("t6_s_ready1", s_ready, 4'b0010);
    tick();
    check("t6_grant1", grant_id, 1);
    check("t6_data1", md_rx_data, 32'h44444444);
    check("t6_rrptr2", dut.rr_ptr_reg, 2);
    s_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
